// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN job sequencer: FSM encoding, default sizes,
// and the packed descriptor width.
package cnn_seq_pkg;

  localparam int W_DEF       = 7;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 4095;
  localparam int TAGW_DEF    = 8;
  localparam int DESC_W_DEF  = 3 * W_DEF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } seq_state_e;

  function automatic int desc_w(input int w);
    return 3 * w;
  endfunction

endpackage

// File: rtl/cnn_job_fifo.sv
// Descriptor queue: DEPTH x DW, registered occupancy, head visible combinationally.
// Push is refused when full and pop is refused when empty.
module cnn_job_fifo #(
  parameter int DW    = 21,
  parameter int DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_wr, w_rd;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  // Full is taken from the registered level, so a same-cycle pop never frees a slot.
  assign w_wr = i_push & ~o_full;
  assign w_rd = i_pop  & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/cnn_job_sequencer.sv
// Queues X/Y/Z job descriptors and launches them one at a time into the CNN
// main-process stage, waiting for a done edge (or timeout) and reporting with a tag.
module cnn_job_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TAGW    = TAGW_DEF
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [W-1:0]           inX,
  input  logic [W-1:0]           inY,
  input  logic [W-1:0]           inZ,
  output logic                   start,
  output logic [W-1:0]           X,
  output logic [W-1:0]           Y,
  output logic [W-1:0]           Z,
  input  logic                   doneIn,
  output logic                   jobDone,
  output logic [TAGW-1:0]        jobTag,
  output logic                   jobErr,
  output logic                   errSticky,
  input  logic                   errClr,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int DW = desc_w(W);
  localparam int CW = $clog2(TIMEOUT + 1);

  seq_state_e    r_state, w_nxt;
  logic [W-1:0]  r_x, r_y, r_z;
  logic [TAGW-1:0] r_tag_cnt, r_tag;
  logic [CW-1:0] r_tcnt;
  logic          r_err, r_sticky, r_done_q;
  logic [DW-1:0] w_head;
  logic          w_full, w_empty, w_pop, w_edge, w_timeout;

  cnn_job_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (inValid),
    .i_data  ({inX, inY, inZ}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Only a fresh rising edge completes a job; a held-high done is ignored.
  assign w_edge = doneIn & ~r_done_q;
  assign w_pop  = (r_state == S_IDLE) & ~w_empty;

  always_comb begin
    w_nxt     = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:   if (!w_empty) w_nxt = S_LAUNCH;
      S_LAUNCH: w_nxt = S_RUN;
      S_RUN: begin
        if (w_edge) begin
          w_nxt = S_REPORT;
        end else if (r_tcnt == CW'(TIMEOUT)) begin
          w_nxt     = S_REPORT;
          w_timeout = 1'b1;
        end
      end
      S_REPORT: w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_tag_cnt <= '0;
      r_tag     <= '0;
      r_tcnt    <= '0;
      r_err     <= 1'b0;
      r_sticky  <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_done_q <= doneIn;
      if (w_pop) begin
        {r_x, r_y, r_z} <= w_head;
        r_tag           <= r_tag_cnt;
        r_tag_cnt       <= r_tag_cnt + 1'b1;
      end
      if (r_state == S_LAUNCH) r_tcnt <= '0;
      else if (r_state == S_RUN && !w_edge && !w_timeout) r_tcnt <= r_tcnt + 1'b1;
      if (r_state == S_RUN && w_nxt == S_REPORT) r_err <= w_timeout;
      if (w_timeout)   r_sticky <= 1'b1;
      else if (errClr) r_sticky <= 1'b0;
    end
  end

  assign inReady   = ~w_full;
  assign start     = (r_state == S_LAUNCH);
  assign jobDone   = (r_state == S_REPORT);
  assign jobErr    = (r_state == S_REPORT) & r_err;
  assign jobTag    = r_tag;
  assign errSticky = r_sticky;
  assign busy      = (r_state != S_IDLE) | ~w_empty;
  assign X         = r_x;
  assign Y         = r_y;
  assign Z         = r_z;

endmodule
